fir_bank_mac: RTL and testbench

Parametrised multi-channel FIR filter bank. All channels share one tapped sample delay line and each has its own coefficient set. One time-multiplexed MAC pass runs per accepted input sample, processing two taps per channel per clock, with coefficient pairs fetched from external synchronous memory. Sits between the sample source and the per-band output consumers. Adds rounding, saturation, busy/valid handshaking and overrun detection.

---
 rtl/fir_bank_pkg.sv | 26 ++
 rtl/fir_mac_lane.sv | 70 +++++++
 rtl/fir_bank_mac.sv | 124 ++++++++++++
 tb/tb_fir_bank_mac.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_bank_pkg.sv
// Shared definitions for the multi-channel FIR bank: FSM encoding, defaults
// and a constant-evaluable clog2 used to size address and accumulator widths.
package fir_bank_pkg;

   localparam int DEFAULT_DW    = 16;
   localparam int DEFAULT_CW    = 18;
   localparam int DEFAULT_NTAPS = 128;
   localparam int DEFAULT_NCH   = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      ROUND
   } fir_state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// One channel of the FIR bank: two-tap MAC per clock into a wide accumulator,
// then round-half-up, saturate and register the channel output.
module fir_mac_lane
   import fir_bank_pkg::*;
#(
   parameter int DW     = DEFAULT_DW,
   parameter int CW     = DEFAULT_CW,
   parameter int ACCW   = 40,
   parameter int OSHIFT = CW - 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 acc_en,
   input  logic                 round_en,
   input  logic signed [DW-1:0] sample_even,
   input  logic signed [DW-1:0] sample_odd,
   input  logic [2*CW-1:0]      coef_pair,
   output logic [DW-1:0]        result
);

   localparam logic signed [ACCW:0] ROUND_BIAS = (ACCW+1)'(1) << (OSHIFT - 1);
   localparam logic signed [ACCW:0] OUT_MAX    = (ACCW+1)'((longint'(1) << (DW - 1)) - 1);
   localparam logic signed [ACCW:0] OUT_MIN    = -OUT_MAX - (ACCW+1)'(1);

   logic signed [CW-1:0]    coef_even;
   logic signed [CW-1:0]    coef_odd;
   logic signed [DW+CW-1:0] prod_even;
   logic signed [DW+CW-1:0] prod_odd;
   logic signed [ACCW-1:0]  acc;
   logic signed [ACCW-1:0]  acc_next;
   logic signed [ACCW:0]    biased;
   logic signed [ACCW:0]    shifted;
   logic [DW-1:0]           saturated;

   assign coef_even = coef_pair[2*CW-1:CW];
   assign coef_odd  = coef_pair[CW-1:0];
   assign prod_even = sample_even * coef_even;
   assign prod_odd  = sample_odd * coef_odd;
   assign acc_next  = acc + ACCW'(prod_even) + ACCW'(prod_odd);

   // One extra bit above the accumulator keeps the rounding bias from wrapping.
   always_comb begin
      biased    = (ACCW+1)'(acc) + ROUND_BIAS;
      shifted   = biased >>> OSHIFT;
      saturated = shifted[DW-1:0];
      if (shifted > OUT_MAX) begin
         saturated = {1'b0, {(DW-1){1'b1}}};
      end else if (shifted < OUT_MIN) begin
         saturated = {1'b1, {(DW-1){1'b0}}};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc    <= '0;
         result <= '0;
      end else begin
         if (clear) begin
            acc <= '0;
         end else if (acc_en) begin
            acc <= acc_next;
         end
         if (round_en) begin
            result <= saturated;
         end
      end
   end

endmodule

// File: rtl/fir_bank_mac.sv
// Multi-channel FIR bank: shared sample delay line, one time-multiplexed MAC
// pass per accepted sample, coefficient pairs fetched from external memory.
module fir_bank_mac
   import fir_bank_pkg::*;
#(
   parameter int DW     = DEFAULT_DW,
   parameter int CW     = DEFAULT_CW,
   parameter int NTAPS  = DEFAULT_NTAPS,
   parameter int NCH    = DEFAULT_NCH,
   parameter int OSHIFT = CW - 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DW-1:0]         datain,
   input  logic                  din_enable,
   output logic                  busy,
   output logic                  overrun,
   output logic [clog2(NTAPS/2)-1:0] coeffaddress,
   input  logic [NCH*2*CW-1:0]   coeffs,
   output logic [NCH*DW-1:0]     dataout,
   output logic                  dout_valid
);

   localparam int P    = NTAPS / 2;
   localparam int AW   = clog2(P);
   localparam int ACCW = DW + CW + clog2(NTAPS);

   fir_state_t           state;
   logic signed [DW-1:0] delay_line [NTAPS];
   logic signed [DW-1:0] even_taps  [P];
   logic signed [DW-1:0] odd_taps   [P];
   logic signed [DW-1:0] sample_even;
   logic signed [DW-1:0] sample_odd;
   logic [AW-1:0]        pair_index;
   logic                 acc_en;
   logic                 accept;
   logic                 round_en;

   assign accept   = (state == IDLE) && din_enable;
   assign round_en = (state == ROUND);
   assign busy     = (state != IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NTAPS; i++) begin
            delay_line[i] <= '0;
         end
      end else if (accept) begin
         delay_line[0] <= datain;
         for (int i = 1; i < NTAPS; i++) begin
            delay_line[i] <= delay_line[i-1];
         end
      end
   end

   // Memory answers one clock late, so the tap pair and accumulate enable
   // trail the address by one cycle; this is what makes DRAIN necessary.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         coeffaddress <= '0;
         overrun      <= 1'b0;
         dout_valid   <= 1'b0;
         pair_index   <= '0;
         acc_en       <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         acc_en     <= (state == RUN);
         pair_index <= coeffaddress;
         if (din_enable && (state != IDLE)) begin
            overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (din_enable) begin
                  coeffaddress <= '0;
                  state        <= RUN;
               end
            end
            RUN: begin
               if (coeffaddress == AW'(P - 1)) begin
                  state <= DRAIN;
               end else begin
                  coeffaddress <= coeffaddress + 1'b1;
               end
            end
            DRAIN: state <= ROUND;
            ROUND: begin
               dout_valid <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < P; k++) begin : g_pairs
      assign even_taps[k] = delay_line[2*k];
      assign odd_taps[k]  = delay_line[2*k+1];
   end

   assign sample_even = even_taps[pair_index];
   assign sample_odd  = odd_taps[pair_index];

   for (genvar c = 0; c < NCH; c++) begin : g_lanes
      fir_mac_lane #(
         .DW     (DW),
         .CW     (CW),
         .ACCW   (ACCW),
         .OSHIFT (OSHIFT)
      ) u_lane (
         .clock       (clock),
         .reset       (reset),
         .clear       (accept),
         .acc_en      (acc_en),
         .round_en    (round_en),
         .sample_even (sample_even),
         .sample_odd  (sample_odd),
         .coef_pair   (coeffs[c*2*CW +: 2*CW]),
         .result      (dataout[c*DW +: DW])
      );
   end

endmodule

// File: tb/tb_fir_bank_mac.sv
// Self-checking bench for fir_bank_mac: directed and random passes compared
// against a direct convolution model of the filter bank.
module tb_fir_bank_mac;

   localparam int DW     = 16;
   localparam int CW     = 18;
   localparam int NTAPS  = 128;
   localparam int NCH    = 8;
   localparam int OSHIFT = CW - 1;
   localparam int P      = NTAPS / 2;
   localparam int AW     = 6;
   localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
   localparam longint MINV = -(longint'(1) << (DW - 1));

   logic                 clock;
   logic                 reset;
   logic [DW-1:0]        datain;
   logic                 din_enable;
   logic                 busy;
   logic                 overrun;
   logic [AW-1:0]        coeffaddress;
   logic [NCH*2*CW-1:0]  coeffs;
   logic [NCH*DW-1:0]    dataout;
   logic                 dout_valid;

   logic signed [CW-1:0] coef [NCH][NTAPS];
   logic signed [DW-1:0] hist [NTAPS];
   int                   checks;
   int                   errors;
   logic                 sawValid;

   fir_bank_mac #(
      .DW(DW), .CW(CW), .NTAPS(NTAPS), .NCH(NCH), .OSHIFT(OSHIFT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .datain       (datain),
      .din_enable   (din_enable),
      .busy         (busy),
      .overrun      (overrun),
      .coeffaddress (coeffaddress),
      .coeffs       (coeffs),
      .dataout      (dataout),
      .dout_valid   (dout_valid)
   );

   always #5 clock = ~clock;

   // External synchronous coefficient memory: data for an address one clock later.
   always @(posedge clock) begin
      for (int c = 0; c < NCH; c++) begin
         coeffs[c*2*CW +: 2*CW] <= {coef[c][2*coeffaddress], coef[c][2*coeffaddress+1]};
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic modelClear();
      for (int i = 0; i < NTAPS; i++) hist[i] = '0;
   endtask

   task automatic modelPush(input logic signed [DW-1:0] s);
      for (int i = NTAPS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = s;
   endtask

   function automatic logic [DW-1:0] modelOut(input int c);
      longint acc;
      longint r;
      logic [63:0] rv;
      acc = 0;
      for (int i = 0; i < NTAPS; i++) acc += longint'(hist[i]) * longint'(coef[c][i]);
      r = (acc + (longint'(1) << (OSHIFT - 1))) >>> OSHIFT;
      if (r > MAXV) r = MAXV;
      else if (r < MINV) r = MINV;
      rv = r;
      return rv[DW-1:0];
   endfunction

   task automatic checkModel(input string tag);
      for (int c = 0; c < NCH; c++) begin
         checkOutput($sformatf("%s_ch%0d", tag, c), 64'(dataout[c*DW +: DW]), 64'(modelOut(c)));
      end
   endtask

   task automatic setTap0(input logic [CW-1:0] v);
      for (int c = 0; c < NCH; c++) begin
         for (int i = 0; i < NTAPS; i++) coef[c][i] = '0;
         coef[c][0] = v;
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_dataout"}, 64'(dataout == '0), 64'(1));
      checkOutput({tag, "_dout_valid"}, 64'(dout_valid), 64'(0));
      checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
      checkOutput({tag, "_overrun"}, 64'(overrun), 64'(0));
      checkOutput({tag, "_coeffaddress"}, 64'(coeffaddress), 64'(0));
   endtask

   // Starts in an IDLE cycle; extraAt > 0 injects a second strobe while busy.
   task automatic applyStimulus(input string tag, input logic [DW-1:0] sample, input int extraAt);
      int n;
      datain     = sample;
      din_enable = 1'b1;
      tick();
      din_enable = 1'b0;
      modelPush(sample);
      checkOutput({tag, "_busy_after_accept"}, 64'(busy), 64'(1));
      n = 1;
      while (!dout_valid && n < 200) begin
         if (n == extraAt) begin
            datain     = DW'($urandom);
            din_enable = 1'b1;
         end
         tick();
         din_enable = 1'b0;
         n++;
      end
      checkOutput({tag, "_latency"}, 64'(n), 64'(P + 3));
      checkModel(tag);
   endtask

   initial begin
      clock      = 1'b0;
      reset      = 1'b1;
      din_enable = 1'b0;
      datain     = '0;
      checks     = 0;
      errors     = 0;
      for (int c = 0; c < NCH; c++) begin
         for (int i = 0; i < NTAPS; i++) coef[c][i] = '0;
      end
      modelClear();

      #2 reset = 1'b0;
      repeat (3) begin
         @(negedge clock);
         datain     = DW'($urandom);
         din_enable = 1'($urandom);
      end
      checkResetState("por");
      din_enable = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      tick();

      $display("[TB] impulse");
      setTap0(18'h10000);
      applyStimulus("impulse", 16'h4000, 0);
      for (int c = 0; c < NCH; c++) checkOutput($sformatf("impulse_val_ch%0d", c), 64'(dataout[c*DW +: DW]), 64'h2000);

      $display("[TB] rounding");
      setTap0(18'h10000);
      applyStimulus("round_half", 16'h0001, 0);
      checkOutput("round_half_val", 64'(dataout[DW-1:0]), 64'h0001);
      setTap0(18'h0FFFF);
      applyStimulus("round_below_half", 16'h0001, 0);
      checkOutput("round_below_half_val", 64'(dataout[DW-1:0]), 64'h0000);
      setTap0(18'h08000);
      applyStimulus("round_quarter", 16'h0001, 0);
      checkOutput("round_quarter_val", 64'(dataout[DW-1:0]), 64'h0000);
      setTap0(18'h10000);
      applyStimulus("round_neg_half", 16'hFFFF, 0);
      checkOutput("round_neg_half_val", 64'(dataout[DW-1:0]), 64'h0000);

      $display("[TB] saturation");
      for (int c = 0; c < NCH; c++) begin
         for (int i = 0; i < NTAPS; i++) coef[c][i] = 18'h1FFFF;
      end
      for (int s = 0; s < NTAPS; s++) applyStimulus("sat_pos", 16'h7FFF, 0);
      checkOutput("sat_pos_val", 64'(dataout[DW-1:0]), 64'h7FFF);
      for (int s = 0; s < NTAPS; s++) applyStimulus("sat_neg", 16'h8000, 0);
      checkOutput("sat_neg_val", 64'(dataout[DW-1:0]), 64'h8000);
      checkOutput("overrun_still_clear", 64'(overrun), 64'(0));

      $display("[TB] random passes with overrun");
      for (int pass = 0; pass < 6; pass++) begin
         for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < NTAPS; i++) coef[c][i] = CW'($urandom);
         end
         applyStimulus("random", DW'($urandom), (pass == 1) ? 10 : ((pass == 4) ? 40 : 0));
      end
      checkOutput("overrun_sticky", 64'(overrun), 64'(1));

      $display("[TB] async reset while idle");
      #2;
      reset      = 1'b0;
      datain     = DW'($urandom);
      din_enable = 1'b1;
      #1;
      checkResetState("idle_reset");
      din_enable = 1'b0;
      modelClear();
      @(posedge clock);
      #3 reset = 1'b1;
      tick();

      $display("[TB] reset mid-pass");
      setTap0(18'h10000);
      applyStimulus("pre_abort", 16'h1234, 0);
      datain     = 16'h4000;
      din_enable = 1'b1;
      tick();
      din_enable = 1'b0;
      repeat (29) tick();
      #2 reset = 1'b0;
      #1;
      checkResetState("abort_reset");
      modelClear();
      @(posedge clock);
      #3 reset = 1'b1;
      sawValid = 1'b0;
      repeat (P + 10) begin
         tick();
         if (dout_valid) sawValid = 1'b1;
      end
      checkOutput("abort_no_valid", 64'(sawValid), 64'(0));
      checkOutput("abort_dataout_zero", 64'(dataout == '0), 64'(1));
      applyStimulus("post_abort_impulse", 16'h4000, 0);
      for (int c = 0; c < NCH; c++) checkOutput($sformatf("post_abort_val_ch%0d", c), 64'(dataout[c*DW +: DW]), 64'h2000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
